// File: rtl/mac_dot_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mac_dot_sequencer_if
// Purpose  : Groups the operand-buffer handshake and the MAC operand/result
//            bus seen by mac_dot_sequencer.
//   master : sequencer side (drives op_req and the mac_* operands, receives
//            op_vld/op_a/op_b and mac_dout/mac_dout_vld)
//   slave  : operand buffer + MAC side (the opposite directions)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface mac_dot_sequencer_if #(
  parameter int N = 32
);
  // Operand buffer handshake
  logic          op_req;
  logic          op_vld;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  // MAC bus
  logic          mac_addend_vld;
  logic [31:0]   mac_addend;
  logic          mac_multiplicand_vld;
  logic [N-1:0]  mac_multiplicand;
  logic [N-1:0]  mac_multiplier;
  logic [31:0]   mac_dout;
  logic          mac_dout_vld;

  modport master (
    output op_req,
    input  op_vld, op_a, op_b,
    output mac_addend_vld, mac_addend,
    output mac_multiplicand_vld, mac_multiplicand, mac_multiplier,
    input  mac_dout, mac_dout_vld
  );

  modport slave (
    input  op_req,
    output op_vld, op_a, op_b,
    input  mac_addend_vld, mac_addend,
    input  mac_multiplicand_vld, mac_multiplicand, mac_multiplier,
    output mac_dout, mac_dout_vld
  );
endinterface
`default_nettype wire

// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mac_dot_sequencer
// Purpose  : Drives one MAC through a TAPS-long dot product
//            (bias + sum a_i*b_i). Per tap: issue the running partial sum as
//            the addend, fetch an operand pair, issue multiplicand/multiplier,
//            then wait for the MAC result, which becomes the next addend.
// Ports    : clk, rst_n   - clock, synchronous active-low reset
//            i_start      - begin a dot product (sampled only when idle)
//            i_bias_din   - initial partial sum, captured on start
//            i_relu_en    - clamp a negative result to 0, captured on start
//            o_busy       - high whenever not idle
//            o_sum_dout   - final result, held until the next result
//            o_sum_vld    - one-cycle result strobe
//            o_err        - one-cycle strobe on MAC result timeout
//            bus          - operand handshake + MAC bus (master side)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module mac_dot_sequencer #(
  parameter int N       = 32,
  parameter int TAPS    = 25,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [31:0]         i_bias_din,
  input  logic                i_relu_en,
  output logic                o_busy,
  output logic [31:0]         o_sum_dout,
  output logic                o_sum_vld,
  output logic                o_err,
  mac_dot_sequencer_if.master bus
);

  // Timeout counter only needs to reach TIMEOUT-1 (the expiry test fires there).
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_TAP_LAST = CNT_W'(TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_WAIT_OP  = 3'd2,
    S_MUL      = 3'd3,
    S_WAIT_MAC = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_relu;
  logic [CNT_W-1:0]  r_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_busy;
  logic              r_op_req;
  logic              r_addend_vld;
  logic [31:0]       r_addend;      // doubles as the running accumulator
  logic              r_mcand_vld;
  logic [N-1:0]      r_mcand;
  logic [N-1:0]      r_mplier;
  logic [31:0]       r_sum_dout;
  logic              r_sum_vld;
  logic              r_err;

  // Every output is set on entry into the state that owns it, so each one
  // is a plain register with no decode behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_relu       <= 1'b0;
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_busy       <= 1'b0;
      r_op_req     <= 1'b0;
      r_addend_vld <= 1'b0;
      r_addend     <= '0;
      r_mcand_vld  <= 1'b0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_sum_dout   <= '0;
      r_sum_vld    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Strobes default low; they are only ever one cycle wide.
      r_addend_vld <= 1'b0;
      r_mcand_vld  <= 1'b0;
      r_sum_vld    <= 1'b0;
      r_err        <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_relu       <= i_relu_en;
            r_cnt        <= '0;
            r_addend     <= i_bias_din;
            r_addend_vld <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ADD;
          end
        end

        S_ADD: begin
          r_op_req <= 1'b1;
          r_state  <= S_WAIT_OP;
        end

        S_WAIT_OP: begin
          if (r_op_req && bus.op_vld) begin
            r_op_req    <= 1'b0;
            r_mcand     <= bus.op_a;
            r_mplier    <= bus.op_b;    // held until the next accepted pair
            r_mcand_vld <= 1'b1;
            r_state     <= S_MUL;
          end
        end

        S_MUL: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_MAC;
        end

        S_WAIT_MAC: begin
          if (bus.mac_dout_vld) begin
            if (r_cnt == C_TAP_LAST) begin
              r_sum_dout <= (r_relu && bus.mac_dout[31]) ? 32'd0 : bus.mac_dout;
              r_sum_vld  <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_cnt        <= r_cnt + 1'b1;
              r_addend     <= bus.mac_dout;
              r_addend_vld <= 1'b1;
              r_state      <= S_ADD;
            end
          end else if (r_tmo == C_TMO_LAST) begin
            // MAC never answered: abandon the partial sum.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy   <= 1'b0;
          r_op_req <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy                   = r_busy;
  assign o_sum_dout               = r_sum_dout;
  assign o_sum_vld                = r_sum_vld;
  assign o_err                    = r_err;
  assign bus.op_req               = r_op_req;
  assign bus.mac_addend_vld       = r_addend_vld;
  assign bus.mac_addend           = r_addend;
  assign bus.mac_multiplicand_vld = r_mcand_vld;
  assign bus.mac_multiplicand     = r_mcand;
  assign bus.mac_multiplier       = r_mplier;

endmodule
`default_nettype wire
